// File: rtl/uart_prog_loader_pkg.sv
// Shared encodings for the UART program loader: loader FSM, RX FSM, word sizing.
package uart_prog_loader_pkg;

    typedef enum logic [2:0] {
        L_IDLE,
        L_HDR,
        L_DATA,
        L_DONE,
        L_ERR
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;

    // Bytes per memory word for an arbitrary (multiple-of-8) word width.
    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/uart_prog_loader_rx.sv
// UART byte receiver: 2-FF synchroniser, mid-bit sampling, 8N1, LSB first.
module uart_rx
    import uart_prog_loader_pkg::*;
#(
    parameter int CLOCK_PER_BIT = 1000
) (
    input  logic       clk,
    input  logic       a_reset,
    input  logic       uart_in,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int              CNT_W = $clog2(CLOCK_PER_BIT);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLOCK_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLOCK_PER_BIT - 1);

    logic       sync1_q, sync2_q;
    rx_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;

    // Synchroniser idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= uart_in;
            sync2_q <= sync1_q;
        end
    end

    // RX state machine: half-bit to centre on the start bit, then full-bit steps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: if (!sync2_q) begin
                state_d = RX_START;
                cnt_d   = HALF;
            end
            RX_START: if (cnt_q == '0) begin
                if (!sync2_q) begin
                    state_d = RX_DATA;
                    cnt_d   = FULL;
                    bit_d   = '0;
                end else begin
                    state_d = RX_IDLE;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            RX_DATA: if (cnt_q == '0) begin
                shift_d = {sync2_q, shift_q[7:1]};
                cnt_d   = FULL;
                bit_d   = bit_q + 1'b1;
                if (bit_q == 3'd7) state_d = RX_STOP;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            RX_STOP: if (cnt_q == '0) begin
                state_d = RX_IDLE;
                if (sync2_q) begin
                    valid_d = 1'b1;
                    data_d  = shift_q;
                end else begin
                    ferr_d  = 1'b1;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // RX state and registered byte/error pulses.
    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign byte_data  = data_q;
    assign byte_valid = valid_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Serial program loader: header word N, then N words written from address 0.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 8,
    parameter int RAM_DEPTH     = 2 ** ADDR_WIDTH,
    parameter int CLOCK_PER_BIT = 1000,
    parameter int TIMEOUT_BITS  = 32
) (
    input  logic                  clk,
    input  logic                  a_reset,
    input  logic                  enable,
    input  logic                  uart_in,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  frame_error,
    output logic                  overflow_error,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int BPW    = bytes_per_word(DATA_WIDTH);
    localparam int PH_W   = $clog2(BPW) + 1;
    localparam int TO_CYC = TIMEOUT_BITS * CLOCK_PER_BIT;
    localparam int TO_W   = $clog2(TO_CYC);
    localparam int CMP_W  = ((DATA_WIDTH > ADDR_WIDTH + 1) ? DATA_WIDTH : ADDR_WIDTH + 1) + 1;
    localparam logic [PH_W-1:0]  LAST_PH = PH_W'(BPW - 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TO_CYC - 1);
    localparam logic [CMP_W-1:0] DEPTH_C = CMP_W'(RAM_DEPTH);

    logic [7:0] byte_data;
    logic       byte_valid, frame_err;

    uart_rx #(.CLOCK_PER_BIT(CLOCK_PER_BIT)) u_rx (
        .clk        (clk),
        .a_reset    (a_reset),
        .uart_in    (uart_in),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    logic [PH_W-1:0]       phase_q, phase_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d, word_c;
    logic [TO_W-1:0]       to_q, to_d;
    logic                  asm_active, word_done;
    logic [CMP_W-1:0]      word_ext;

    ld_state_e             state_q, state_d;
    logic [ADDR_WIDTH:0]   n_q, n_d, wc_q, wc_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wen_q, wen_d, busy_q, busy_d, done_q, done_d;
    logic                  ferr_q, ferr_d, ovf_q, ovf_d;

    // Word assembly: high byte first; partial words die on timeout or when not loading.
    always_comb begin
        asm_active = enable && (state_q == L_HDR || state_q == L_DATA);
        word_done  = asm_active && byte_valid && (phase_q == LAST_PH);
        word_c     = asm_q << 8;
        word_c[7:0] = byte_data;
        word_ext   = CMP_W'(word_c);
        phase_d    = phase_q;
        asm_d      = asm_q;
        to_d       = to_q;
        if (!asm_active) begin
            phase_d = '0;
            to_d    = '0;
        end else if (byte_valid) begin
            asm_d   = word_c;
            to_d    = '0;
            phase_d = word_done ? '0 : phase_q + 1'b1;
        end else if (phase_q != '0) begin
            if (to_q == TO_LAST) begin
                phase_d = '0;
                to_d    = '0;
            end else begin
                to_d = to_q + 1'b1;
            end
        end else begin
            to_d = '0;
        end
    end

    // Assembly registers.
    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            phase_q <= '0;
            asm_q   <= '0;
            to_q    <= '0;
        end else begin
            phase_q <= phase_d;
            asm_q   <= asm_d;
            to_q    <= to_d;
        end
    end

    // Loader next-state: enable low overrides everything, including a completing word.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        wc_d    = wc_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wen_d   = 1'b0;
        ferr_d  = ferr_q;
        ovf_d   = ovf_q;
        if (!enable) begin
            state_d = L_IDLE;
            ferr_d  = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                L_IDLE: begin
                    state_d = L_HDR;
                    wc_d    = '0;
                    addr_d  = '0;
                    ferr_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
                L_HDR: if (frame_err) begin
                    ferr_d  = 1'b1;
                    state_d = L_ERR;
                end else if (word_done) begin
                    if (word_ext == '0) begin
                        state_d = L_DONE;
                    end else if (word_ext > DEPTH_C) begin
                        ovf_d   = 1'b1;
                        state_d = L_ERR;
                    end else begin
                        n_d     = word_ext[ADDR_WIDTH:0];
                        state_d = L_DATA;
                    end
                end
                L_DATA: if (frame_err) begin
                    ferr_d  = 1'b1;
                    state_d = L_ERR;
                end else if (word_done) begin
                    wen_d   = 1'b1;
                    wdata_d = word_c;
                    addr_d  = wc_q[ADDR_WIDTH-1:0];
                    wc_d    = wc_q + 1'b1;
                    if (wc_q + 1'b1 == n_q) state_d = L_DONE;
                end
                default: ;
            endcase
        end
        busy_d = (state_d == L_HDR) || (state_d == L_DATA);
        done_d = (state_d == L_DONE);
    end

    // Loader FSM with registered outputs.
    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            state_q <= L_IDLE;
            n_q     <= '0;
            wc_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            wc_q    <= wc_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign mem_wen        = wen_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign frame_error    = ferr_q;
    assign overflow_error = ovf_q;
    assign word_count     = wc_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader at 16 clocks per UART bit.
module tb_uart_prog_loader;

    localparam int DW  = 16;
    localparam int AW  = 8;
    localparam int CPB = 16;

    logic          clk = 1'b0;
    logic          a_reset, enable, uart_in;
    logic          mem_wen, busy, done, frame_error, overflow_error;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [AW:0]   word_count;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];

    uart_prog_loader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLOCK_PER_BIT(CPB), .TIMEOUT_BITS(32)
    ) dut (
        .clk(clk), .a_reset(a_reset), .enable(enable), .uart_in(uart_in),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .frame_error(frame_error),
        .overflow_error(overflow_error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Memory-side scoreboard: log every write strobe.
    always @(negedge clk) begin
        if (mem_wen) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_in = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_in = stop;
        repeat (CPB) @(negedge clk);
        uart_in = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log;
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic test_reset;
        a_reset = 1'b1; enable = 1'b0; uart_in = 1'b1;
        idle(3);
        checks++;
        if ({mem_wen, busy, done, frame_error, overflow_error} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b want 00000",
                {mem_wen, busy, done, frame_error, overflow_error});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== '0) begin
            errors++; $display("FAIL reset_mem got addr=%h data=%h want 0", mem_addr, mem_wdata);
        end
        checks++;
        if (word_count !== '0) begin
            errors++; $display("FAIL reset_wc got %0d want 0", word_count);
        end
        a_reset = 1'b0;
        idle(3);
    endtask

    task automatic test_basic;
        clear_log();
        enable = 1'b1;
        idle(2);
        send_byte(8'h00, 1); send_byte(8'h02, 1);
        send_byte(8'h12, 1); send_byte(8'h34, 1);
        send_byte(8'hAB, 1); send_byte(8'hCD, 1);
        idle(20);
        checks++;
        if (wa_q.size() !== 2) begin
            errors++; $display("FAIL basic_nwr got %0d want 2", wa_q.size());
        end else begin
            checks++;
            if (wa_q[0] !== 8'd0 || wd_q[0] !== 16'h1234) begin
                errors++; $display("FAIL basic_wr0 got (%0d,%h) want (0,1234)", wa_q[0], wd_q[0]);
            end
            checks++;
            if (wa_q[1] !== 8'd1 || wd_q[1] !== 16'hABCD) begin
                errors++; $display("FAIL basic_wr1 got (%0d,%h) want (1,abcd)", wa_q[1], wd_q[1]);
            end
        end
        checks++;
        if (word_count !== 9'd2) begin
            errors++; $display("FAIL basic_wc got %0d want 2", word_count);
        end
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++; $display("FAIL basic_done_busy got %b want 10", {done, busy});
        end
        enable = 1'b0;
        idle(3);
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++; $display("FAIL basic_disable got %b want 00", {done, busy});
        end
    endtask

    task automatic test_zero_header;
        clear_log();
        enable = 1'b1;
        idle(2);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL zero_busy got %b want 1", busy);
        end
        send_byte(8'h00, 1); send_byte(8'h00, 1);
        idle(10);
        checks++;
        if (done !== 1'b1 || wa_q.size() !== 0) begin
            errors++; $display("FAIL zero_done got done=%b writes=%0d want 1,0", done, wa_q.size());
        end
        enable = 1'b0;
        idle(3);
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++; $display("FAIL zero_disable got %b want 00", {done, busy});
        end
    endtask

    task automatic test_overflow;
        clear_log();
        enable = 1'b1;
        idle(2);
        send_byte(8'h01, 1); send_byte(8'h01, 1);
        idle(10);
        checks++;
        if ({overflow_error, busy, done} !== 3'b100) begin
            errors++; $display("FAIL ovf_flag got %b want 100", {overflow_error, busy, done});
        end
        send_byte(8'h00, 1); send_byte(8'h01, 1);
        send_byte(8'h12, 1); send_byte(8'h34, 1);
        idle(10);
        checks++;
        if (wa_q.size() !== 0 || word_count !== '0) begin
            errors++; $display("FAIL ovf_nowr got writes=%0d wc=%0d want 0,0", wa_q.size(), word_count);
        end
        checks++;
        if (overflow_error !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky got %b want 1", overflow_error);
        end
        enable = 1'b0;
        idle(3);
        checks++;
        if (overflow_error !== 1'b0) begin
            errors++; $display("FAIL ovf_clear got %b want 0", overflow_error);
        end
    endtask

    task automatic test_frame_error;
        clear_log();
        enable = 1'b1;
        idle(2);
        send_byte(8'h00, 1); send_byte(8'h03, 1);
        send_byte(8'h11, 1); send_byte(8'h22, 1);
        send_byte(8'h77, 0);
        idle(40);
        send_byte(8'h33, 1); send_byte(8'h44, 1);
        idle(10);
        checks++;
        if (wa_q.size() !== 1) begin
            errors++; $display("FAIL fe_nwr got %0d want 1", wa_q.size());
        end else begin
            checks++;
            if (wa_q[0] !== 8'd0 || wd_q[0] !== 16'h1122) begin
                errors++; $display("FAIL fe_wr0 got (%0d,%h) want (0,1122)", wa_q[0], wd_q[0]);
            end
        end
        checks++;
        if ({frame_error, busy, done} !== 3'b100 || word_count !== 9'd1) begin
            errors++; $display("FAIL fe_flag got fe/busy/done=%b wc=%0d want 100,1",
                {frame_error, busy, done}, word_count);
        end
        enable = 1'b0;
        idle(3);
        checks++;
        if (frame_error !== 1'b0) begin
            errors++; $display("FAIL fe_clear got %b want 0", frame_error);
        end
        idle(200);
    endtask

    task automatic test_glitch_timeout;
        clear_log();
        enable = 1'b1;
        idle(2);
        uart_in = 1'b0;
        idle(4);
        uart_in = 1'b1;
        idle(40);
        send_byte(8'h00, 1); send_byte(8'h01, 1);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL glitch_hdr got busy=%b done=%b want 1,0", busy, done);
        end
        send_byte(8'h55, 1);
        idle(32 * CPB + 100);
        checks++;
        if (wa_q.size() !== 0) begin
            errors++; $display("FAIL to_early_wr got %0d want 0", wa_q.size());
        end
        send_byte(8'h12, 1); send_byte(8'h34, 1);
        idle(10);
        checks++;
        if (wa_q.size() !== 1) begin
            errors++; $display("FAIL to_nwr got %0d want 1", wa_q.size());
        end else begin
            checks++;
            if (wa_q[0] !== 8'd0 || wd_q[0] !== 16'h1234) begin
                errors++; $display("FAIL to_wr0 got (%0d,%h) want (0,1234)", wa_q[0], wd_q[0]);
            end
        end
        checks++;
        if (done !== 1'b1 || word_count !== 9'd1) begin
            errors++; $display("FAIL to_done got done=%b wc=%0d want 1,1", done, word_count);
        end
        enable = 1'b0;
        idle(3);
    endtask

    task automatic test_reset_midop;
        clear_log();
        enable = 1'b1;
        idle(2);
        send_byte(8'h00, 1); send_byte(8'h02, 1);
        send_byte(8'h12, 1);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL rst_pre_busy got %b want 1", busy);
        end
        @(negedge clk);
        #2 a_reset = 1'b1;
        #1;
        checks++;
        if ({mem_wen, busy, done, frame_error, overflow_error} !== 5'b0 || word_count !== '0) begin
            errors++; $display("FAIL rst_async got flags=%b wc=%0d want 00000,0",
                {mem_wen, busy, done, frame_error, overflow_error}, word_count);
        end
        idle(3);
        a_reset = 1'b0;
        idle(5);
        send_byte(8'h00, 1); send_byte(8'h02, 1);
        send_byte(8'h12, 1); send_byte(8'h34, 1);
        send_byte(8'hAB, 1); send_byte(8'hCD, 1);
        idle(20);
        checks++;
        if (wa_q.size() !== 2) begin
            errors++; $display("FAIL rst_nwr got %0d want 2", wa_q.size());
        end else begin
            checks++;
            if (wa_q[0] !== 8'd0 || wd_q[0] !== 16'h1234 || wa_q[1] !== 8'd1 || wd_q[1] !== 16'hABCD) begin
                errors++; $display("FAIL rst_wr got (%0d,%h)(%0d,%h) want (0,1234)(1,abcd)",
                    wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
            end
        end
        checks++;
        if (done !== 1'b1 || word_count !== 9'd2) begin
            errors++; $display("FAIL rst_done got done=%b wc=%0d want 1,2", done, word_count);
        end
        enable = 1'b0;
        idle(3);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_header();
        test_overflow();
        test_frame_error();
        test_glitch_timeout();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
